// File: rtl/enemy_bomb_pos_if.sv
// Enemy bomb bus: game-side inputs (run enable, enemy and player positions)
// and the bomb pool / game-status outputs consumed by the renderer and the
// score logic.
//   master : game datapath side (drives enable/epx/epy/ppx/ppy)
//   slave  : enemy_bomb_pos (drives bomb positions, bactive, hit, lives, game_over)
interface enemy_bomb_pos_if;
  logic       enable;
  logic [9:0] epx;
  logic [9:0] epy;
  logic [9:0] ppx;
  logic [9:0] ppy;
  logic [9:0] bx0;
  logic [9:0] by0;
  logic [9:0] bx1;
  logic [9:0] by1;
  logic [1:0] bactive;
  logic       hit;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output enable, epx, epy, ppx, ppy,
    input  bx0, by0, bx1, by1, bactive, hit, lives, game_over
  );

  modport slave (
    input  enable, epx, epy, ppx, ppy,
    output bx0, by0, bx1, by1, bactive, hit, lives, game_over
  );
endinterface

// File: rtl/enemy_bomb_pos.sv
// Enemy bomb logic: two-slot bomb pool dropped from the enemy position on a
// periodic fire timer, player hit-box collision, lives counter and sticky
// game-over flag.
// Ports:
//   game_clk : game tick clock, all state updates on its rising edge
//   reset    : synchronous active-high reset
//   bus      : enemy_bomb_pos_if.slave (enable, enemy/player positions in;
//              bomb positions, bactive, hit, lives, game_over out)
module enemy_bomb_pos #(
  parameter int FIRE_PERIOD   = 120,
  parameter int BOMB_STEP     = 2,
  parameter int SCREEN_BOTTOM = 479,
  parameter int PLAYER_W      = 40,
  parameter int PLAYER_H      = 20,
  parameter int LIVES         = 3
) (
  input logic             game_clk,
  input logic             reset,
  enemy_bomb_pos_if.slave bus
);

  localparam int               FW        = $clog2(FIRE_PERIOD);
  localparam logic [FW-1:0]    FCNT_LAST = FW'(FIRE_PERIOD - 1);
  localparam logic [10:0]      STEP11    = 11'(BOMB_STEP);
  localparam logic [10:0]      BOTTOM11  = 11'(SCREEN_BOTTOM);
  localparam logic [10:0]      PW_M1     = 11'(PLAYER_W - 1);
  localparam logic [10:0]      PH_M1     = 11'(PLAYER_H - 1);

  logic [FW-1:0] fcnt;
  logic [9:0]    bx [2];
  logic [9:0]    by [2];
  logic [1:0]    act;
  logic          hit_q;
  logic [1:0]    lives_q;
  logic          game_over_q;

  logic          fire_tick;
  logic          running;
  logic [1:0]    slot_hit;
  logic [1:0]    slot_exit;
  logic [10:0]   by_next [2];
  logic [10:0]   box_x_lo, box_x_hi, box_y_lo, box_y_hi;

  // All compares in 11 bits so the box right/bottom edge and the next bomb
  // row never wrap.
  always_comb begin
    fire_tick = (fcnt == FCNT_LAST);
    running   = bus.enable && !game_over_q;
    box_x_lo  = {1'b0, bus.ppx};
    box_x_hi  = {1'b0, bus.ppx} + PW_M1;
    box_y_lo  = {1'b0, bus.ppy};
    box_y_hi  = {1'b0, bus.ppy} + PH_M1;
    for (int i = 0; i < 2; i++) begin
      by_next[i]   = {1'b0, by[i]} + STEP11;
      slot_hit[i]  = act[i] &&
                     ({1'b0, bx[i]} >= box_x_lo) && ({1'b0, bx[i]} <= box_x_hi) &&
                     ({1'b0, by[i]} >= box_y_lo) && ({1'b0, by[i]} <= box_y_hi);
      slot_exit[i] = act[i] && !slot_hit[i] && (by_next[i] > BOTTOM11);
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      fcnt        <= '0;
      bx[0]       <= '0;
      by[0]       <= '0;
      bx[1]       <= '0;
      by[1]       <= '0;
      act         <= 2'b00;
      hit_q       <= 1'b0;
      lives_q     <= 2'(LIVES);
      game_over_q <= 1'b0;
    end else if (running) begin
      fcnt  <= fire_tick ? '0 : fcnt + FW'(1);
      hit_q <= |slot_hit;

      for (int i = 0; i < 2; i++) begin
        if (slot_hit[i] || slot_exit[i]) begin
          act[i] <= 1'b0;
        end else if (act[i]) begin
          by[i] <= by_next[i][9:0];
        end
      end

      // Launch looks at occupancy from the start of the cycle, so a slot
      // freed this cycle stays empty until the next fire tick.
      if (fire_tick) begin
        if (!act[0]) begin
          bx[0]  <= bus.epx;
          by[0]  <= bus.epy;
          act[0] <= 1'b1;
        end else if (!act[1]) begin
          bx[1]  <= bus.epx;
          by[1]  <= bus.epy;
          act[1] <= 1'b1;
        end
      end

      // Simultaneous hits on both slots cost a single life.
      if (|slot_hit) begin
        if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
        if (lives_q <= 2'd1) begin
          game_over_q <= 1'b1;
          act         <= 2'b00;
        end
      end
    end else begin
      hit_q <= 1'b0;
    end
  end

  assign bus.bx0       = bx[0];
  assign bus.by0       = by[0];
  assign bus.bx1       = bx[1];
  assign bus.by1       = by[1];
  assign bus.bactive   = act;
  assign bus.hit       = hit_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_enemy_bomb_pos.sv
// Self-checking bench for enemy_bomb_pos: a cycle model predicts the full
// output state each cycle (pushed to a queue when the inputs are driven,
// popped after the edge), plus directed checks of the key scenarios.
module tb_enemy_bomb_pos;
  localparam int FP     = 120;
  localparam int STEP   = 2;
  localparam int BOTTOM = 479;
  localparam int PW     = 40;
  localparam int PH     = 20;
  localparam int NLIVES = 3;

  logic game_clk;
  logic reset;
  enemy_bomb_pos_if bus ();

  enemy_bomb_pos #(
    .FIRE_PERIOD  (FP),
    .BOMB_STEP    (STEP),
    .SCREEN_BOTTOM(BOTTOM),
    .PLAYER_W     (PW),
    .PLAYER_H     (PH),
    .LIVES        (NLIVES)
  ) dut (
    .game_clk(game_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int       m_fcnt;
  int       m_bx [2];
  int       m_by [2];
  bit [1:0] m_act;
  bit       m_hit;
  int       m_lives;
  bit       m_go;

  logic [45:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [45:0] model_pack();
    return {10'(m_bx[0]), 10'(m_by[0]), 10'(m_bx[1]), 10'(m_by[1]),
            m_act, m_hit, 2'(m_lives), m_go};
  endfunction

  function automatic logic [45:0] obs_pack();
    return {bus.bx0, bus.by0, bus.bx1, bus.by1,
            bus.bactive, bus.hit, bus.lives, bus.game_over};
  endfunction

  // Next-state model evaluated with the inputs present before the edge.
  task automatic model_step();
    bit [1:0] was;
    bit       h;
    int       px, py;
    if (reset) begin
      m_fcnt = 0; m_bx[0] = 0; m_by[0] = 0; m_bx[1] = 0; m_by[1] = 0;
      m_act = 2'b00; m_hit = 0; m_lives = NLIVES; m_go = 0;
    end else if (!bus.enable || m_go) begin
      m_hit = 0;
    end else begin
      px  = int'(bus.ppx);
      py  = int'(bus.ppy);
      was = m_act;
      h   = 0;
      for (int s = 0; s < 2; s++) begin
        if (m_act[s]) begin
          if (m_bx[s] >= px && m_bx[s] < px + PW && m_by[s] >= py && m_by[s] < py + PH) begin
            m_act[s] = 0;
            h = 1;
          end else if (m_by[s] + STEP > BOTTOM) begin
            m_act[s] = 0;
          end else begin
            m_by[s] = m_by[s] + STEP;
          end
        end
      end
      if (m_fcnt == FP - 1) begin
        m_fcnt = 0;
        if (!was[0]) begin
          m_bx[0] = int'(bus.epx); m_by[0] = int'(bus.epy); m_act[0] = 1;
        end else if (!was[1]) begin
          m_bx[1] = int'(bus.epx); m_by[1] = int'(bus.epy); m_act[1] = 1;
        end
      end else begin
        m_fcnt++;
      end
      m_hit = h;
      if (h) begin
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) begin
          m_go  = 1;
          m_act = 2'b00;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    exp_q.push_back(model_pack());
    @(posedge game_clk);
    #1;
    if (!reset) cyc++;
    chk("sb_state", 64'(obs_pack()), 64'(exp_q.pop_front()));
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic set_in(input int ex, input int ey, input int px, input int py);
    bus.epx = 10'(ex);
    bus.epy = 10'(ey);
    bus.ppx = 10'(px);
    bus.ppy = 10'(py);
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    set_in(300, 100, 0, 0);

    // Launch timing and descent, then bottom exit.
    reset_dut();
    chk("rst_lives", 64'(bus.lives), 64'(3));
    chk("rst_bactive", 64'(bus.bactive), 64'(0));
    chk("rst_go", 64'(bus.game_over), 64'(0));
    run_to(119);
    chk("t1_no_launch_119", 64'(bus.bactive), 64'(2'b00));
    step();
    chk("t1_bactive_120", 64'(bus.bactive), 64'(2'b01));
    chk("t1_bx0_120", 64'(bus.bx0), 64'(300));
    chk("t1_by0_120", 64'(bus.by0), 64'(100));
    step();
    chk("t1_by0_121", 64'(bus.by0), 64'(102));
    step();
    chk("t1_by0_122", 64'(bus.by0), 64'(104));
    run_to(309);
    chk("t2_by0_478", 64'(bus.by0), 64'(478));
    chk("t2_active_309", 64'(bus.bactive), 64'(2'b11));
    step();
    chk("t2_exit_bactive", 64'(bus.bactive), 64'(2'b10));
    chk("t2_exit_nohit", 64'(bus.hit), 64'(0));
    chk("t2_exit_lives", 64'(bus.lives), 64'(3));

    // Single hit, and left-edge / just-outside box positions.
    set_in(300, 100, 290, 200);
    reset_dut();
    run_to(170);
    chk("t3_by0_200", 64'(bus.by0), 64'(200));
    chk("t3_nohit_170", 64'(bus.hit), 64'(0));
    step();
    chk("t3_hit", 64'(bus.hit), 64'(1));
    chk("t3_cleared", 64'(bus.bactive), 64'(2'b00));
    chk("t3_lives", 64'(bus.lives), 64'(2));
    step();
    chk("t3_hit_pulse_end", 64'(bus.hit), 64'(0));

    set_in(300, 100, 261, 200);
    reset_dut();
    run_to(171);
    chk("t3_edge_hit", 64'(bus.hit), 64'(1));
    chk("t3_edge_lives", 64'(bus.lives), 64'(2));

    set_in(300, 100, 301, 200);
    reset_dut();
    run_to(175);
    chk("t3_miss_lives", 64'(bus.lives), 64'(3));
    chk("t3_miss_active", 64'(bus.bactive), 64'(2'b01));

    // Both slots land on the box in the same cycle.
    set_in(300, 100, 290, 340);
    reset_dut();
    run_to(120);
    bus.epy = 10'(340);
    run_to(240);
    chk("t4_both_active", 64'(bus.bactive), 64'(2'b11));
    chk("t4_by0", 64'(bus.by0), 64'(340));
    chk("t4_by1", 64'(bus.by1), 64'(340));
    step();
    chk("t4_hit", 64'(bus.hit), 64'(1));
    chk("t4_cleared", 64'(bus.bactive), 64'(2'b00));
    chk("t4_one_life", 64'(bus.lives), 64'(2));
    step();
    chk("t4_single_pulse", 64'(bus.hit), 64'(0));
    chk("t4_lives_hold", 64'(bus.lives), 64'(2));

    // Three hits end the game; only reset recovers.
    set_in(300, 100, 290, 200);
    reset_dut();
    run_to(171);
    chk("t5_lives_2", 64'(bus.lives), 64'(2));
    run_to(291);
    chk("t5_lives_1", 64'(bus.lives), 64'(1));
    run_to(410);
    chk("t5_go_before", 64'(bus.game_over), 64'(0));
    step();
    chk("t5_lives_0", 64'(bus.lives), 64'(0));
    chk("t5_go", 64'(bus.game_over), 64'(1));
    chk("t5_bactive_clr", 64'(bus.bactive), 64'(2'b00));
    run_to(650);
    chk("t5_no_launch", 64'(bus.bactive), 64'(2'b00));
    chk("t5_go_sticky", 64'(bus.game_over), 64'(1));
    chk("t5_lives_sat", 64'(bus.lives), 64'(0));
    reset_dut();
    chk("t5_rst_lives", 64'(bus.lives), 64'(3));
    chk("t5_rst_go", 64'(bus.game_over), 64'(0));

    // Freeze mid-flight, then reset mid-flight.
    set_in(300, 100, 0, 0);
    reset_dut();
    run_to(130);
    chk("t6_by0_pre", 64'(bus.by0), 64'(120));
    bus.enable = 1'b0;
    for (int k = 0; k < 50; k++) step();
    chk("t6_by0_frozen", 64'(bus.by0), 64'(120));
    chk("t6_bx0_frozen", 64'(bus.bx0), 64'(300));
    chk("t6_active_frozen", 64'(bus.bactive), 64'(2'b01));
    chk("t6_lives_frozen", 64'(bus.lives), 64'(3));
    bus.enable = 1'b1;
    run_to(289);
    chk("t6_fcnt_held", 64'(bus.bactive), 64'(2'b01));
    step();
    chk("t6_launch_late", 64'(bus.bactive), 64'(2'b11));
    run_to(300);
    reset = 1'b1;
    step();
    chk("t6_rst_bactive", 64'(bus.bactive), 64'(0));
    chk("t6_rst_pos", 64'({bus.bx0, bus.by0, bus.bx1, bus.by1}), 64'(0));
    chk("t6_rst_hit", 64'(bus.hit), 64'(0));
    chk("t6_rst_lives", 64'(bus.lives), 64'(3));
    chk("t6_rst_go", 64'(bus.game_over), 64'(0));
    reset = 1'b0;
    cyc = 0;
    run_to(120);
    chk("t6_relaunch", 64'(bus.bactive), 64'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enemy_bomb_pos.md
Name: enemy_bomb_pos

Overview:
Downward counterpart of the player missile logic. The enemy block drops bombs from its position toward the player's ship, and a hit on the player costs one life. The block keeps a two-slot bomb pool, a periodic fire timer, player-box collision detection, a lives counter and a sticky game-over flag. It sits beside the player missile logic in the game datapath and feeds bomb coordinates to the VGA renderer and game status to the score/display logic.

Parameters:
FIRE_PERIOD, 120, game_clk cycles between enemy fire attempts (>=2)
BOMB_STEP, 2, pixels a bomb descends per enabled game_clk cycle (1..15)
SCREEN_BOTTOM, 479, last visible row; a bomb leaves the screen when its next y would exceed this
PLAYER_W, 40, player hit-box width in pixels
PLAYER_H, 20, player hit-box height in pixels
LIVES, 3, starting lives (1..3)

Ports:
game_clk  input  1  game tick clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  game running; when low, all state is frozen
epx  input  10  enemy block x (bomb launch x)
epy  input  10  enemy block y (bomb launch y)
ppx  input  10  player hit-box left x
ppy  input  10  player hit-box top y
bx0, by0  output  10 each  bomb slot 0 position
bx1, by1  output  10 each  bomb slot 1 position
bactive  output  2  bit i high = slot i falling (renderer draws only active slots)
hit  output  1  one-cycle pulse when any bomb strikes the player
lives  output  2  remaining lives
game_over  output  1  sticky, high once lives reaches 0

Behaviour:
- Reset:
  - Sampled on the game_clk edge only.
  - Sets bx*/by* = 0, bactive = 0, hit = 0, lives = LIVES, game_over = 0, fire counter = 0.
  - Overrides every other input, including mid-flight bombs.
- Freeze: when enable = 0 or game_over = 1, the fire counter, slots and lives hold, and hit = 0.
- Fire timer:
  - fcnt counts 0..FIRE_PERIOD-1 and wraps.
  - fire_tick is asserted internally on cycles where fcnt == FIRE_PERIOD-1.
  - First fire_tick comes FIRE_PERIOD cycles after reset release with enable high.
- Launch:
  - On fire_tick, the lowest-indexed slot that was inactive at the start of the cycle loads bx = epx, by = epy and sets bactive.
  - A slot freed in the same cycle is not reused until the next fire_tick.
  - Both slots busy: the fire is dropped, with no queueing.
- Per active slot, each enabled cycle, in priority order:
  1. Hit, if ppx <= bx <= ppx+PLAYER_W-1 and ppy <= by <= ppy+PLAYER_H-1, tested on the current registered position. The slot goes inactive and the slot hit flag is set.
  2. Exit, else if by + BOMB_STEP > SCREEN_BOTTOM. The slot goes inactive with no hit.
  3. Move, else by <= by + BOMB_STEP, with bx unchanged.
- Inactive slots hold their last bx/by.
- Comparisons and sums use 11-bit arithmetic; ppx+PLAYER_W and by+BOMB_STEP never wrap.
- Hit pulse and lives:
  - hit (registered) = OR of the slot hit flags. The pulse appears on the edge that deactivates the slot.
  - Both slots hitting in the same cycle produce one pulse and one life lost.
  - lives decrements by 1 per pulse and saturates at 0.
  - On the edge where lives becomes 0, game_over is set and all bactive bits clear.
  - game_over clears only on reset.
- Latency: launch is visible 1 cycle after fire_tick. The first move is on the following cycle.
- A launch and another slot's hit can occur in the same cycle; both take effect.

Test Plan:
1. Reset, enable = 1, epx = 300, epy = 100, player far away (ppx = 0, ppy = 0) -> bactive = 01 with bx0 = 300, by0 = 100 exactly 120 cycles after reset release; by0 = 102, 104, ... on the following cycles.
2. Same setup, run on -> slot 0 goes inactive on the cycle after by0 = 478 (478+2 > 479), with no hit and lives = 3.
3. epx = 300, epy = 100, ppx = 290, ppy = 200 -> hit pulses 1 cycle, slot 0 clears on the edge after by0 = 200, lives 3 -> 2. With ppx = 261 (box 261..300) hit still occurs; with ppx = 301 there is no hit.
4. Force both slots active and aligned on the player box in the same cycle -> a single hit pulse, and lives drops by exactly 1.
5. Three hits -> lives = 0, game_over = 1, bactive = 00; further fire_ticks launch nothing, and only reset restores lives = 3 and game_over = 0.
6. enable low for 50 cycles mid-flight -> bx/by, fcnt and lives are unchanged. Assert reset mid-flight with enable high -> all outputs return to reset values on the next edge.
